flow_ctrl_param: RTL
====================

// Module: flow_ctrl_param
// PURPOSE
//  Parametrised flow controller between one shared upstream FIFO (index 0) and NUM_CH per-channel downstream FIFOs (index 1..NUM_CH).
//  Registers all FIFO status flags into buses and generates the per-channel continue vector cf with a pause/run FSM per channel.
//  Each FSM applies a minimum pause hold and almost-empty release hysteresis.
//  Drives the upstream pop enable and keeps saturating per-channel pause-cycle counters for debug and statistics.
// PARAMETERS
//  NUM_CH    4  number of downstream channels; FIFO count NF = NUM_CH+1 (localparam)
//  HOLD_CYC  2  minimum extra cycles a channel stays paused after its last pause cause (>=0)
//  CNT_W     8  width of each pause-cycle statistics counter
// PORTS
//  clk               in   1          clock, all state updates on rising edge
//  reset_L           in   1          asynchronous active-low reset
//  almost_full_in    in   NF         raw almost-full flags, bit i = FIFO i
//  full_in           in   NF         raw full flags
//  almost_empty_in   in   NF         raw almost-empty flags
//  empty_in          in   NF         raw empty flags
//  continuar         in   NUM_CH     external run request per channel (1=run, 0=pause request)
//  clr_stats         in   1          synchronous clear of all pause counters
//  almost_full       out  NF         registered copy of almost_full_in
//  full              out  NF         registered copy of full_in
//  almost_empty      out  NF         registered copy of almost_empty_in
//  empty             out  NF         registered copy of empty_in
//  cf                out  NUM_CH     continue per channel (1=channel may accept data)
//  pop_en            out  1          read enable for FIFO 0
//  pause_cycles      out  NUM_CH*CNT_W  flat bus; slice i = cycles channel i was paused
// BEHAVIOUR
//  Reset (reset_L=0, async):
//   - almost_full, full, almost_empty = 0; empty = all ones.
//   - Every channel FSM = PAUSE with hold count 0; cf = 0; pop_en = 0; pause_cycles = 0.
//  Flag buses: each is a 1-cycle registered copy of its input (latency 1, no filtering).
//  Per-channel i (downstream FIFO j=i+1); raw inputs are sampled at each edge:
//   - cause_i   = almost_full_in[j] | full_in[j] | ~continuar[i]
//   - release_i = (almost_empty_in[j] | empty_in[j]) & continuar[i] & ~full_in[j]
//   - FSM states RUN (cf[i]=1) and PAUSE (cf[i]=0); hcnt width = $clog2(HOLD_CYC+1), min 1.
//   - RUN: if cause_i -> PAUSE, hcnt<=HOLD_CYC; else stay RUN.
//   - PAUSE, checked in priority order:
//       cause_i   -> hcnt<=HOLD_CYC (reload);
//       hcnt!=0   -> hcnt<=hcnt-1;
//       release_i -> RUN;
//       otherwise stay PAUSE.
//   - Cause always dominates release when both are true in the same cycle.
//   - Hysteresis: dropping almost_full alone never releases; the FIFO must reach almost-empty or empty.
//   - A 1-cycle cause pulse gives cf[i]=0 for at least HOLD_CYC+1 cycles. cf changes 1 cycle after the sampled cause.
//  pop_en = ~empty_in[0] & (&cf), combinational on cf (registered) and raw empty_in[0].
//  pause_cycles[i]:
//   - At each edge, if clr_stats -> 0; else if cf[i]==0 and not all-ones -> +1.
//   - Saturates at 2^CNT_W-1; no wrap-around.
//   - clr_stats beats increment on the same edge.
//  Reset asserted mid-operation: immediate return to reset values, counters included; no pending hold is retained.
// TESTING (NUM_CH=4, HOLD_CYC=2, CNT_W=8)
//  1. Reset, then empty_in=5'h1F, continuar=4'hF:
//     - cf=0, empty=5'h1F while reset_L=0.
//     - First edge after release: cf=4'hF; pop_en stays 0 (FIFO0 empty).
//  2. From RUN, pulse almost_full_in[1] for 1 cycle, almost_empty_in[1]=1:
//     - cf[0]=0 for exactly 3 cycles, then 1; other cf bits stay 1.
//  3. Hysteresis: pause ch2, then drop almost_full_in[3] with almost_empty_in[3]=empty_in[3]=0 for 10 cycles:
//     - cf[2] stays 0.
//     - Assert almost_empty_in[3]: cf[2]=1 on the next edge.
//  4. continuar=4'b0001 with all FIFOs empty:
//     - cf becomes 4'b0001 after 1 edge; pop_en=0.
//     - Restore continuar=4'hF: cf=4'hF 3 edges later.
//  5. Hold ch0 paused 300 cycles: pause_cycles[7:0]=8'hFF (saturated).
//     - Pulse clr_stats together with a paused cycle: slice reads 0.
//  6. Drop reset_L asynchronously mid-hold:
//     - All outputs reach reset values without waiting for a clock edge.
//     - Flag buses follow the inputs 1 cycle after reset release.

Source files
------------

// File: rtl/flow_ctrl_param.sv
// Flow controller between a shared upstream FIFO (index 0) and NUM_CH downstream FIFOs.
// Registers FIFO status, runs a pause/run FSM with hold and hysteresis per channel, and counts pause cycles.
module flow_ctrl_param #(
    parameter int  NUM_CH   = 4,
    parameter int  HOLD_CYC = 2,
    parameter int  CNT_W    = 8,
    localparam int NF       = NUM_CH + 1
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NF-1:0]           almost_full_in,
    input  logic [NF-1:0]           full_in,
    input  logic [NF-1:0]           almost_empty_in,
    input  logic [NF-1:0]           empty_in,
    input  logic [NUM_CH-1:0]       continuar,
    input  logic                    clr_stats,
    output logic [NF-1:0]           almost_full,
    output logic [NF-1:0]           full,
    output logic [NF-1:0]           almost_empty,
    output logic [NF-1:0]           empty,
    output logic [NUM_CH-1:0]       cf,
    output logic                    pop_en,
    output logic [NUM_CH*CNT_W-1:0] pause_cycles
);

    localparam int HW = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC);

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    logic [NF-1:0]    r_almost_full;
    logic [NF-1:0]    r_full;
    logic [NF-1:0]    r_almost_empty;
    logic [NF-1:0]    r_empty;
    state_t           r_state    [NUM_CH];
    state_t           w_state_nxt[NUM_CH];
    logic [HW-1:0]    r_hcnt     [NUM_CH];
    logic [HW-1:0]    w_hcnt_nxt [NUM_CH];
    logic [CNT_W-1:0] r_cnt      [NUM_CH];
    logic [NUM_CH-1:0] w_cause;
    logic [NUM_CH-1:0] w_release;

    // Status flag registers; empty resets high so nothing is read before real status arrives
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_almost_full  <= '0;
            r_full         <= '0;
            r_almost_empty <= '0;
            r_empty        <= '1;
        end else begin
            r_almost_full  <= almost_full_in;
            r_full         <= full_in;
            r_almost_empty <= almost_empty_in;
            r_empty        <= empty_in;
        end
    end

    // Pause causes and release conditions from raw flags; channel i watches FIFO i+1
    always_comb begin
        w_cause   = '0;
        w_release = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_cause[i]   = almost_full_in[i+1] | full_in[i+1] | ~continuar[i];
            w_release[i] = (almost_empty_in[i+1] | empty_in[i+1]) & continuar[i] & ~full_in[i+1];
        end
    end

    // Per-channel next state: cause reloads the hold, release only after the hold has drained
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hcnt_nxt[i]  = r_hcnt[i];
            case (r_state[i])
                ST_RUN: begin
                    if (w_cause[i]) begin
                        w_state_nxt[i] = ST_PAUSE;
                        w_hcnt_nxt[i]  = HOLD_LD;
                    end else begin
                        w_state_nxt[i] = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (w_cause[i]) begin
                        w_hcnt_nxt[i] = HOLD_LD;
                    end else if (r_hcnt[i] != {HW{1'b0}}) begin
                        w_hcnt_nxt[i] = r_hcnt[i] - {{(HW-1){1'b0}}, 1'b1};
                    end else if (w_release[i]) begin
                        w_state_nxt[i] = ST_RUN;
                    end else begin
                        w_state_nxt[i] = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt[i] = ST_PAUSE;
                    w_hcnt_nxt[i]  = {HW{1'b0}};
                end
            endcase
        end
    end

    // Channel FSM state and hold counters
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_PAUSE;
                r_hcnt[i]  <= {HW{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hcnt[i]  <= w_hcnt_nxt[i];
            end
        end
    end

    // Saturating pause-cycle counters; clear wins over increment
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_stats) begin
                    r_cnt[i] <= {CNT_W{1'b0}};
                end else if ((r_state[i] == ST_PAUSE) && (r_cnt[i] != {CNT_W{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Output mapping from registered state
    always_comb begin
        almost_full  = r_almost_full;
        full         = r_full;
        almost_empty = r_almost_empty;
        empty        = r_empty;
        cf           = '0;
        pause_cycles = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cf[i]                          = (r_state[i] == ST_RUN);
            pause_cycles[i*CNT_W +: CNT_W] = r_cnt[i];
        end
    end

    assign pop_en = ~empty_in[0] & (&cf);

endmodule
